// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bundle between the multicycle controller and its RV32I datapath
//   master (controller): in op, branch_taken, mem_ready; out memory handshake, mux selects,
//                        write enables, decoded imm_src/alu_op, retired count, state_dbg
//   slave (datapath):    the mirror image of master
interface multicycle_controller_if #(
   parameter int WIDTH_OP  = 7,
   parameter int CNT_WIDTH = 32
);
   logic [WIDTH_OP-1:0]  op;
   logic                 branch_taken;
   logic                 mem_ready;
   logic                 mem_req;
   logic                 mem_write;
   logic                 adr_src;
   logic                 ir_write;
   logic                 pc_write;
   logic                 reg_write;
   logic [1:0]           alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           result_src;
   logic [2:0]           imm_src;
   logic [2:0]           alu_op;
   logic [CNT_WIDTH-1:0] retired;
   logic [3:0]           state_dbg;
   modport master (
      input  op, branch_taken, mem_ready,
      output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, result_src, imm_src, alu_op, retired, state_dbg
   );
   modport slave (
      output op, branch_taken, mem_ready,
      input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, result_src, imm_src, alu_op, retired, state_dbg
   );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing one RV32I instruction at a time through a shared ALU/memory datapath
//   clk_i   : clock, all state updates on the rising edge
//   rst_n_i : synchronous active-low reset; while low every control output except retired/state_dbg is 0
//   ctl_if  : master side of multicycle_controller_if (opcode, branch result, memory handshake in;
//             selects, enables, imm_src/alu_op, retired counter and state_dbg out)
//   ILLEGAL_TRAP_EN : when defined an illegal opcode parks the FSM in TRAP until reset;
//                     otherwise it retires as a NOP
module multicycle_controller #(
   parameter int WIDTH_OP  = 7,
   parameter int CNT_WIDTH = 32
) (
   input logic                    clk_i,
   input logic                    rst_n_i,
   multicycle_controller_if.master ctl_if
);
   localparam logic [WIDTH_OP-1:0] OP_LOAD  = 7'b0000011;
   localparam logic [WIDTH_OP-1:0] OP_STORE = 7'b0100011;
   localparam logic [WIDTH_OP-1:0] OP_R     = 7'b0110011;
   localparam logic [WIDTH_OP-1:0] OP_I     = 7'b0010011;
   localparam logic [WIDTH_OP-1:0] OP_B     = 7'b1100011;
   localparam logic [WIDTH_OP-1:0] OP_JAL   = 7'b1101111;
   localparam logic [WIDTH_OP-1:0] OP_JALR  = 7'b1100111;
   localparam logic [WIDTH_OP-1:0] OP_AUIPC = 7'b0010111;
   localparam logic [WIDTH_OP-1:0] OP_LUI   = 7'b0110111;
   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3, S_MEMWB = 4'd4,
      S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9,
      S_JAL = 4'd10, S_JALR = 4'd11, S_LINK = 4'd12, S_UPPER = 4'd13, S_TRAP = 4'd15
   } state_e;
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   logic                 mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire;
   logic [1:0]           alu_src_a, alu_src_b, result_src;
   logic [2:0]           imm_src, alu_op;
   logic [WIDTH_OP-1:0]  op;
   assign op = ctl_if.op;
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      imm_src    = 3'b000;
      alu_op     = 3'b000;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = ctl_if.mem_ready;
            pc_write   = ctl_if.mem_ready;
            state_d    = ctl_if.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // ALUOut captures the branch/jump target while the opcode is being decoded
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = op == OP_JAL ? 3'b101 : 3'b100;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_B:              state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_AUIPC, OP_LUI:  state_d = S_UPPER;
`ifdef ILLEGAL_TRAP_EN
               default:           state_d = S_TRAP;
`else
               default:           state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = op == OP_STORE ? 3'b011 : 3'b001;
            alu_op    = op == OP_STORE ? 3'b010 : 3'b001;
            state_d   = op == OP_STORE ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            state_d = ctl_if.mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            state_d   = ctl_if.mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = 3'b001;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 3'b011;
            pc_write  = ctl_if.branch_taken;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms oldPC+4 for the link write
            pc_write  = 1'b1;
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_op    = 3'b111;
            state_d   = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            imm_src    = 3'b001;
            alu_op     = 3'b110;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_d    = S_LINK;
         end
         S_LINK: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_UPPER: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 3'b010;
            alu_op    = op == OP_LUI ? 3'b101 : 3'b100;
            state_d   = S_ALUWB;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end
   // every path back into FETCH ends an instruction; TRAP never returns there
   assign retire    = state_q != S_FETCH && state_d == S_FETCH;
   assign retired_d = retired_q + CNT_WIDTH'(retire);
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end
   assign ctl_if.mem_req    = rst_n_i & mem_req;
   assign ctl_if.mem_write  = rst_n_i & mem_write;
   assign ctl_if.adr_src    = rst_n_i & adr_src;
   assign ctl_if.ir_write   = rst_n_i & ir_write;
   assign ctl_if.pc_write   = rst_n_i & pc_write;
   assign ctl_if.reg_write  = rst_n_i & reg_write;
   assign ctl_if.alu_src_a  = rst_n_i ? alu_src_a : 2'b00;
   assign ctl_if.alu_src_b  = rst_n_i ? alu_src_b : 2'b00;
   assign ctl_if.result_src = rst_n_i ? result_src : 2'b00;
   assign ctl_if.imm_src    = rst_n_i ? imm_src : 3'b000;
   assign ctl_if.alu_op     = rst_n_i ? alu_op : 3'b000;
   assign ctl_if.retired    = retired_q;
   assign ctl_if.state_dbg  = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: vector table and scoreboard checks of per-cycle state and control outputs
module tb_multicycle_controller;
   typedef struct packed {
      logic [6:0]       op;
      logic             br;
      logic [2:0]       n;
      logic [4:0][3:0]  st;
      logic [4:0][17:0] cw;
   } vec_t;
   typedef struct packed {
      logic        mr;
      logic [3:0]  st;
      logic [17:0] cw;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [17:0] cur_cw;
   int          n_chk = 0;
   int          n_pass = 0;
   int          exp_ret = 0;
   exp_t        q[$];
   vec_t        vecs[10];
   logic [17:0] c_f, c_fw, c_d, c_dj, c_er, c_ei, c_aw, c_ml, c_ms, c_mr, c_mb, c_mw;
   logic [17:0] c_bt, c_bn, c_jl, c_jr, c_lk, c_ua, c_ul;
   multicycle_controller_if #(.WIDTH_OP(7), .CNT_WIDTH(32)) ctl ();
   multicycle_controller dut (.clk_i(clk), .rst_n_i(rst_n), .ctl_if(ctl.master));
   always #5 clk = ~clk;
   assign cur_cw = {ctl.mem_req, ctl.mem_write, ctl.adr_src, ctl.ir_write, ctl.pc_write,
                    ctl.reg_write, ctl.alu_src_a, ctl.alu_src_b, ctl.result_src,
                    ctl.imm_src, ctl.alu_op};
   function automatic logic [17:0] cw(bit mq, bit mw, bit ad, bit ir, bit pw, bit rw,
                                      logic [1:0] a, logic [1:0] b, logic [1:0] r,
                                      logic [2:0] im, logic [2:0] ao);
      return {mq, mw, ad, ir, pw, rw, a, b, r, im, ao};
   endfunction
   function automatic vec_t mk(logic [6:0] op, logic br, logic [2:0] n,
                               logic [3:0] s0, logic [3:0] s1, logic [3:0] s2, logic [3:0] s3,
                               logic [3:0] s4, logic [17:0] k0, logic [17:0] k1,
                               logic [17:0] k2, logic [17:0] k3, logic [17:0] k4);
      vec_t v;
      v.op = op;
      v.br = br;
      v.n  = n;
      v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
      v.cw[0] = k0; v.cw[1] = k1; v.cw[2] = k2; v.cw[3] = k3; v.cw[4] = k4;
      return v;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
   endtask
   task automatic push(logic mr, logic [3:0] st, logic [17:0] k);
      exp_t e;
      e.mr = mr;
      e.st = st;
      e.cw = k;
      q.push_back(e);
   endtask
   task automatic drain(string tag);
      exp_t e;
      int   c = 0;
      while (q.size() > 0) begin
         e = q.pop_front();
         ctl.mem_ready = e.mr;
         @(negedge clk);
         chk($sformatf("%s c%0d state", tag, c), 32'(ctl.state_dbg), 32'(e.st));
         chk($sformatf("%s c%0d ctl", tag, c), 32'(cur_cw), 32'(e.cw));
         c++;
         @(posedge clk);
         #1;
      end
   endtask
   task automatic end_instr(string tag);
      exp_ret++;
      chk($sformatf("%s retired", tag), ctl.retired, 32'(exp_ret));
      chk($sformatf("%s back to fetch", tag), 32'(ctl.state_dbg), 32'd0);
   endtask
   initial begin
      c_f  = cw(1,0,0,1,1,0, 2'd0,2'd2,2'd2, 3'd0,3'd0);
      c_fw = cw(1,0,0,0,0,0, 2'd0,2'd2,2'd2, 3'd0,3'd0);
      c_d  = cw(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd4,3'd0);
      c_dj = cw(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd5,3'd0);
      c_er = cw(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0,3'd0);
      c_ei = cw(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd1,3'd0);
      c_aw = cw(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0,3'd0);
      c_ml = cw(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd1,3'd1);
      c_ms = cw(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd3,3'd2);
      c_mr = cw(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0);
      c_mb = cw(0,0,0,0,0,1, 2'd0,2'd0,2'd1, 3'd0,3'd0);
      c_mw = cw(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0);
      c_bt = cw(0,0,0,0,1,0, 2'd2,2'd0,2'd0, 3'd0,3'd3);
      c_bn = cw(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0,3'd3);
      c_jl = cw(0,0,0,0,1,0, 2'd1,2'd2,2'd0, 3'd0,3'd7);
      c_jr = cw(0,0,0,0,1,0, 2'd2,2'd1,2'd2, 3'd1,3'd6);
      c_lk = cw(0,0,0,0,0,1, 2'd1,2'd2,2'd2, 3'd0,3'd0);
      c_ua = cw(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd2,3'd4);
      c_ul = cw(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd2,3'd5);
      vecs[0] = mk(7'b0110011, 0, 4, 0, 1, 6, 8, 0, c_f, c_d, c_er, c_aw, 0);
      vecs[1] = mk(7'b0010011, 0, 4, 0, 1, 7, 8, 0, c_f, c_d, c_ei, c_aw, 0);
      vecs[2] = mk(7'b0000011, 0, 5, 0, 1, 2, 3, 4, c_f, c_d, c_ml, c_mr, c_mb);
      vecs[3] = mk(7'b0100011, 0, 4, 0, 1, 2, 5, 0, c_f, c_d, c_ms, c_mw, 0);
      vecs[4] = mk(7'b1100011, 1, 3, 0, 1, 9, 0, 0, c_f, c_d, c_bt, 0, 0);
      vecs[5] = mk(7'b1100011, 0, 3, 0, 1, 9, 0, 0, c_f, c_d, c_bn, 0, 0);
      vecs[6] = mk(7'b1101111, 0, 4, 0, 1, 10, 8, 0, c_f, c_dj, c_jl, c_aw, 0);
      vecs[7] = mk(7'b1100111, 0, 4, 0, 1, 11, 12, 0, c_f, c_d, c_jr, c_lk, 0);
      vecs[8] = mk(7'b0010111, 0, 4, 0, 1, 13, 8, 0, c_f, c_d, c_ua, c_aw, 0);
      vecs[9] = mk(7'b0110111, 0, 4, 0, 1, 13, 8, 0, c_f, c_d, c_ul, c_aw, 0);
      ctl.op = 7'b0110011;
      ctl.branch_taken = 1'b0;
      ctl.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset state", 32'(ctl.state_dbg), 32'd0);
      chk("reset ctl forced 0", 32'(cur_cw), 32'd0);
      chk("reset retired", ctl.retired, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ctl.op = vecs[i].op;
         ctl.branch_taken = vecs[i].br;
         for (int k = 0; k < int'(vecs[i].n); k++) push(1'b1, vecs[i].st[k], vecs[i].cw[k]);
         drain($sformatf("vec%0d", i));
         end_instr($sformatf("vec%0d", i));
      end
      ctl.op = 7'b0000011;
      push(1, 0, c_f); push(0, 1, c_d); push(0, 2, c_ml);
      push(0, 3, c_mr); push(0, 3, c_mr); push(0, 3, c_mr); push(1, 3, c_mr);
      push(0, 4, c_mb);
      drain("load wait");
      end_instr("load wait");
      ctl.op = 7'b0100011;
      push(0, 0, c_fw); push(1, 0, c_f); push(0, 1, c_d); push(0, 2, c_ms);
      push(0, 5, c_mw); push(0, 5, c_mw); push(1, 5, c_mw);
      drain("store wait");
      end_instr("store wait");
      ctl.op = 7'b0000000;
      push(1, 0, c_f); push(1, 1, c_d);
`ifdef ILLEGAL_TRAP_EN
      for (int k = 0; k < 10; k++) push(1, 15, 18'd0);
      drain("illegal trap");
      chk("illegal trap retired", ctl.retired, 32'(exp_ret));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_ret = 0;
      chk("trap reset state", 32'(ctl.state_dbg), 32'd0);
`else
      drain("illegal nop");
      end_instr("illegal nop");
`endif
      ctl.op = 7'b0000011;
      push(1, 0, c_f); push(0, 1, c_d); push(0, 2, c_ml); push(0, 3, c_mr);
      drain("load abort");
      rst_n = 1'b0;
      ctl.mem_ready = 1'b1;
      @(negedge clk);
      chk("mid reset ctl forced 0", 32'(cur_cw), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_ret = 0;
      chk("mid reset state", 32'(ctl.state_dbg), 32'd0);
      chk("mid reset retired", ctl.retired, 32'd0);
      ctl.op = 7'b0110011;
      push(1, 0, c_f); push(1, 1, c_d); push(1, 6, c_er); push(1, 8, c_aw);
      drain("R after reset");
      end_instr("R after reset");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
